// File: rtl/dbg_cmd_dispatch.sv
// Resynchronises TCK-domain update-DR/IR toggles into clk and queues them as debug commands.
// Optional DBG_DISPATCH_DROP_CNT_EN enables the saturating dropped-event counter on drop_cnt.
module dbg_cmd_dispatch #(
    parameter int unsigned SR_W        = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned NUM_CH      = 1,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vs_udr_tgl,
    input  logic              vs_uir_tgl,
    input  logic [SR_W-1:0]   sr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [CH_W-1:0]   chan_in,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic              cmd_kind,
    output logic [CH_W-1:0]   cmd_chan,
    output logic [IR_W-1:0]   cmd_ir,
    output logic [SR_W-1:0]   jdo,
    output logic [NUM_CH-1:0] take_action,
    output logic [NUM_CH-1:0] take_no_action,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned SET_W = $clog2(SYNC_STAGES + 2);

    typedef struct packed {
        logic            kind;
        logic [CH_W-1:0] chan;
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } entry_t;

    logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
    logic                   udr_dly_q, uir_dly_q;
    logic [SET_W-1:0]       settle_q;
    logic                   udr_evt, uir_evt;

    logic                   pend_q, pend_d;
    logic [CH_W-1:0]        pend_chan_q, pend_chan_d;
    logic [IR_W-1:0]        pend_ir_q, pend_ir_d;

    entry_t                 mem_q [DEPTH];
    entry_t                 head_q, head_d, push_entry;
    logic                   valid_q;
    logic [LVL_W-1:0]       wr_q, rd_q, wr_d, rd_d, level_q, level_d;
    logic                   push_req, push_ok, pop, full;
    logic [1:0]             drop_n;
    logic [NUM_CH-1:0]      act_q, act_d, noact_q, noact_d;
    logic                   overflow_q;

    // Events are masked until the delay flops hold the post-reset input level.
    assign udr_evt = (settle_q == '0) & (udr_sync_q[SYNC_STAGES-1] ^ udr_dly_q);
    assign uir_evt = (settle_q == '0) & (uir_sync_q[SYNC_STAGES-1] ^ uir_dly_q);

    assign pop  = valid_q & cmd_ready;
    assign full = (level_q == LVL_W'(DEPTH));

    always_comb begin
        push_req    = 1'b0;
        push_entry  = '0;
        pend_d      = pend_q;
        pend_chan_d = pend_chan_q;
        pend_ir_d   = pend_ir_q;
        drop_n      = 2'd0;
        head_d      = head_q;
        act_d       = '0;
        noact_d     = '0;

        // One push slot per cycle: UDR first, then a held UIR, then a fresh UIR.
        if (udr_evt) begin
            push_req   = 1'b1;
            push_entry = '{kind: 1'b0, chan: chan_in, ir: ir_in, data: sr};
            if (uir_evt) begin
                if (pend_q) begin
                    drop_n = drop_n + 2'd1;
                end else begin
                    pend_d      = 1'b1;
                    pend_chan_d = chan_in;
                    pend_ir_d   = ir_in;
                end
            end
        end else if (pend_q) begin
            push_req   = 1'b1;
            push_entry = '{kind: 1'b1, chan: pend_chan_q, ir: pend_ir_q, data: '0};
            pend_d     = 1'b0;
            if (uir_evt) begin
                drop_n = drop_n + 2'd1;
            end
        end else if (uir_evt) begin
            push_req   = 1'b1;
            push_entry = '{kind: 1'b1, chan: chan_in, ir: ir_in, data: '0};
        end

        push_ok = push_req & (~full | pop);
        if (push_req && !push_ok) begin
            drop_n = drop_n + 2'd1;
        end

        wr_d    = wr_q + LVL_W'(push_ok);
        rd_d    = rd_q + LVL_W'(pop);
        level_d = wr_d - rd_d;

        // The just-written slot is the new head only when it is the sole entry.
        if (level_d != '0) begin
            if (push_ok && level_d == LVL_W'(1)) begin
                head_d = push_entry;
            end else begin
                head_d = mem_q[rd_d[AW-1:0]];
            end
        end

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pop && 32'(head_q.chan) == i) begin
                if (head_q.kind) begin
                    noact_d[i] = 1'b1;
                end else begin
                    act_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            udr_sync_q  <= '0;
            uir_sync_q  <= '0;
            udr_dly_q   <= 1'b0;
            uir_dly_q   <= 1'b0;
            settle_q    <= SET_W'(SYNC_STAGES + 1);
            pend_q      <= 1'b0;
            pend_chan_q <= '0;
            pend_ir_q   <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
            valid_q     <= 1'b0;
            head_q      <= '0;
            act_q       <= '0;
            noact_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            udr_sync_q  <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr_tgl};
            uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir_tgl};
            udr_dly_q   <= udr_sync_q[SYNC_STAGES-1];
            uir_dly_q   <= uir_sync_q[SYNC_STAGES-1];
            if (settle_q != '0) begin
                settle_q <= settle_q - SET_W'(1);
            end
            pend_q      <= pend_d;
            pend_chan_q <= pend_chan_d;
            pend_ir_q   <= pend_ir_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            level_q     <= level_d;
            valid_q     <= (level_d != '0);
            head_q      <= head_d;
            act_q       <= act_d;
            noact_q     <= noact_d;
            overflow_q  <= overflow_q | (drop_n != 2'd0);
        end
    end

    // Storage carries no reset; head_q is only loaded from occupied slots.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= push_entry;
        end
    end

`ifdef DBG_DISPATCH_DROP_CNT_EN
    logic [7:0] drop_cnt_q;
    logic [8:0] drop_sum;

    assign drop_sum = {1'b0, drop_cnt_q} + 9'(drop_n);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'h00;
`endif

    assign cmd_valid      = valid_q;
    assign cmd_kind       = head_q.kind;
    assign cmd_chan       = head_q.chan;
    assign cmd_ir         = head_q.ir;
    assign jdo            = head_q.data;
    assign take_action    = act_q;
    assign take_no_action = noact_q;
    assign fifo_level     = level_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_dbg_cmd_dispatch.sv
// Directed bench for dbg_cmd_dispatch: vector table for single commands plus
// hand-written sequences for reset masking, same-cycle events, overflow and reset flush.
module tb_dbg_cmd_dispatch;

    localparam int unsigned SR_W   = 38;
    localparam int unsigned IR_W   = 2;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned LVL_W  = 3;
`ifdef DBG_DISPATCH_DROP_CNT_EN
    localparam logic [7:0] EXP_DROP = 8'd2;
`else
    localparam logic [7:0] EXP_DROP = 8'd0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              vs_udr_tgl, vs_uir_tgl;
    logic [SR_W-1:0]   sr;
    logic [IR_W-1:0]   ir_in;
    logic [CH_W-1:0]   chan_in;
    logic              cmd_ready;
    logic              cmd_valid, cmd_kind, overflow;
    logic [CH_W-1:0]   cmd_chan;
    logic [IR_W-1:0]   cmd_ir;
    logic [SR_W-1:0]   jdo;
    logic [NUM_CH-1:0] take_action, take_no_action;
    logic [LVL_W-1:0]  fifo_level;
    logic [7:0]        drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dbg_cmd_dispatch #(
        .SR_W(SR_W), .IR_W(IR_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .vs_udr_tgl(vs_udr_tgl), .vs_uir_tgl(vs_uir_tgl),
        .sr(sr), .ir_in(ir_in), .chan_in(chan_in), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid), .cmd_kind(cmd_kind), .cmd_chan(cmd_chan), .cmd_ir(cmd_ir),
        .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
        .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic              udr;
        logic [CH_W-1:0]   chan;
        logic [IR_W-1:0]   ir;
        logic [SR_W-1:0]   sr;
        logic              e_kind;
        logic [SR_W-1:0]   e_jdo;
        logic [NUM_CH-1:0] e_act;
        logic [NUM_CH-1:0] e_noact;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(4);
    endtask

    task automatic udr_event(input logic [SR_W-1:0] data);
        sr         = data;
        vs_udr_tgl = ~vs_udr_tgl;
        step(5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 2'd2, 2'b01, 38'h2A_5555_AAAA, 1'b0, 38'h2A_5555_AAAA, 4'b0100, 4'b0000};
        vecs[1] = '{1'b0, 2'd1, 2'b10, 38'h11_2233_4455, 1'b1, 38'h0,            4'b0000, 4'b0010};
        vecs[2] = '{1'b1, 2'd3, 2'b11, 38'h3F_FFFF_FFFF, 1'b0, 38'h3F_FFFF_FFFF, 4'b1000, 4'b0000};
        vecs[3] = '{1'b1, 2'd0, 2'b00, 38'h0,            1'b0, 38'h0,            4'b0001, 4'b0000};
        vecs[4] = '{1'b0, 2'd3, 2'b00, 38'h00_0000_0001, 1'b1, 38'h0,            4'b0000, 4'b1000};

        reset_n    = 1'b0;
        vs_udr_tgl = 1'b1;
        vs_uir_tgl = 1'b0;
        sr         = '0;
        ir_in      = '0;
        chan_in    = '0;
        cmd_ready  = 1'b0;
        step(2);

        chk("rst_valid",    64'(cmd_valid), 64'd0);
        chk("rst_kind",     64'(cmd_kind), 64'd0);
        chk("rst_jdo",      64'(jdo), 64'd0);
        chk("rst_level",    64'(fifo_level), 64'd0);
        chk("rst_act",      64'(take_action), 64'd0);
        chk("rst_noact",    64'(take_no_action), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop",     64'(drop_cnt), 64'd0);

        // A toggle input already high at reset must not create an event.
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("settle_valid", 64'(cmd_valid), 64'd0);
        end
        chk("settle_level", 64'(fifo_level), 64'd0);

        for (int v = 0; v < 5; v++) begin
            chan_in = vecs[v].chan;
            ir_in   = vecs[v].ir;
            sr      = vecs[v].sr;
            if (vecs[v].udr) vs_udr_tgl = ~vs_udr_tgl;
            else             vs_uir_tgl = ~vs_uir_tgl;
            step(2);
            chk("vec_early_valid", 64'(cmd_valid), 64'd0);
            step(1);
            chk("vec_valid", 64'(cmd_valid), 64'd1);
            chk("vec_kind",  64'(cmd_kind), 64'(vecs[v].e_kind));
            chk("vec_chan",  64'(cmd_chan), 64'(vecs[v].chan));
            chk("vec_ir",    64'(cmd_ir), 64'(vecs[v].ir));
            chk("vec_jdo",   64'(jdo), 64'(vecs[v].e_jdo));
            chk("vec_level", 64'(fifo_level), 64'd1);
            cmd_ready = 1'b1;
            step(1);
            cmd_ready = 1'b0;
            chk("vec_act",      64'(take_action), 64'(vecs[v].e_act));
            chk("vec_noact",    64'(take_no_action), 64'(vecs[v].e_noact));
            chk("vec_pop_empty", 64'(cmd_valid), 64'd0);
            step(1);
            chk("vec_act_end",   64'(take_action), 64'd0);
            chk("vec_noact_end", 64'(take_no_action), 64'd0);
        end

        // UDR and UIR in the same cycle: data entry first, IR entry one cycle later.
        chan_in    = 2'd1;
        ir_in      = 2'b10;
        sr         = 38'h15_0F0F_F0F0;
        vs_udr_tgl = ~vs_udr_tgl;
        vs_uir_tgl = ~vs_uir_tgl;
        step(3);
        chk("dual_level1", 64'(fifo_level), 64'd1);
        step(1);
        chk("dual_level2", 64'(fifo_level), 64'd2);
        step(2);
        chk("dual_hold_level", 64'(fifo_level), 64'd2);
        chk("dual_head_kind",  64'(cmd_kind), 64'd0);
        chk("dual_head_jdo",   64'(jdo), 64'h15_0F0F_F0F0);
        cmd_ready = 1'b1;
        step(1);
        chk("dual_act",      64'(take_action), 64'b0010);
        chk("dual_2nd_kind", 64'(cmd_kind), 64'd1);
        chk("dual_2nd_jdo",  64'(jdo), 64'd0);
        chk("dual_2nd_ir",   64'(cmd_ir), 64'b10);
        step(1);
        cmd_ready = 1'b0;
        chk("dual_noact",     64'(take_no_action), 64'b0010);
        chk("dual_act_clear", 64'(take_action), 64'd0);
        chk("dual_empty",     64'(cmd_valid), 64'd0);
        step(1);
        chk("dual_noact_end", 64'(take_no_action), 64'd0);

        // Six events into a four-entry FIFO with no consumer.
        chan_in = 2'd0;
        for (int i = 0; i < 6; i++) udr_event(38'h100 + 38'(i));
        chk("ovf_level",    64'(fifo_level), 64'd4);
        chk("ovf_overflow", 64'(overflow), 64'd1);
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'(EXP_DROP));
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_jdo", 64'(jdo), 64'h100 + 64'(i));
            step(1);
        end
        cmd_ready = 1'b0;
        chk("ovf_drained", 64'(cmd_valid), 64'd0);
        step(1);

        // Full FIFO with push and pop on the same edge.
        do_reset();
        chk("full_ovf_cleared", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) udr_event(38'h200 + 38'(i));
        chk("full_level", 64'(fifo_level), 64'd4);
        sr         = 38'h2FF;
        vs_udr_tgl = ~vs_udr_tgl;
        step(2);
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        chk("full_pp_level",    64'(fifo_level), 64'd4);
        chk("full_pp_overflow", 64'(overflow), 64'd0);
        chk("full_pp_drop",     64'(drop_cnt), 64'd0);
        step(2);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("full_pp_order", 64'(jdo), (i == 3) ? 64'h2FF : 64'h201 + 64'(i));
            step(1);
        end
        cmd_ready = 1'b0;
        chk("full_pp_empty", 64'(cmd_valid), 64'd0);

        // Reset with entries queued and a toggle still in the synchroniser.
        do_reset();
        for (int i = 0; i < 3; i++) udr_event(38'h300 + 38'(i));
        chk("flush_pre_level", 64'(fifo_level), 64'd3);
        vs_udr_tgl = ~vs_udr_tgl;
        step(1);
        reset_n = 1'b0;
        step(1);
        chk("flush_valid", 64'(cmd_valid), 64'd0);
        chk("flush_level", 64'(fifo_level), 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("flush_no_entry", 64'(cmd_valid), 64'd0);
        end
        chk("flush_final_level", 64'(fifo_level), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
